fir_mac_filter: RTL and testbench
=================================

Name: fir_mac_filter

Overview:
Time-multiplexed low-pass FIR stage of the AM receiver. It sits directly downstream of the sample source and is the sole driver and consumer of the signed Q32.32 multiplier block. The multiplier is combinational and is instantiated beside this block: this block drives its two operands and reads back its 64-bit product in the same cycle. Each accepted sample triggers one serial multiply-accumulate pass over TAPS coefficients, producing one filtered Q32.32 sample through a valid/ready output.

Parameters:
TAPS, 8, number of filter taps; power of two, >= 2
AW, $clog2(TAPS), width of the tap index and coefficient address

Ports:
clk  input  1  system clock, all state updates on the rising edge
rst  input  1  synchronous, active-high reset
coef_we  input  1  coefficient write strobe
coef_addr  input  AW  coefficient index h[coef_addr]
coef_data  input  64  coefficient value, signed Q32.32
in_valid  input  1  in_sample is valid
in_ready  output  1  block can accept a sample
in_sample  input  64  input sample, signed Q32.32
mul_a  output  64  multiplier operand A (delay-line tap)
mul_b  output  64  multiplier operand B (coefficient)
mul_c  input  64  multiplier product, combinational from mul_a/mul_b
out_valid  output  1  out_sample is valid
out_ready  input  1  downstream accepts out_sample
out_sample  output  64  filtered sample, signed Q32.32

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset, sampled at a clk edge with rst=1:
  - state=IDLE; idx=0; acc=0.
  - Delay line x[0..TAPS-1]=0 and coefficients h[0..TAPS-1]=0.
  - Outputs: out_valid=0, out_sample=0, mul_a=0, mul_b=0.
  - in_ready=0 while rst=1, and 1 in the first cycle after reset.
  - rst has priority over every other event, including mid-MAC and mid-OUT; no partial result is ever emitted.
- in_ready = (state==IDLE) && !rst. No combinational path from in_valid to in_ready.
- Coefficient writes: honoured only in IDLE, by setting h[coef_addr]=coef_data; ignored in MAC and OUT. A write in the same IDLE cycle as a sample accept takes effect for that computation.
- FSM states IDLE, MAC, OUT:
  - IDLE: on in_valid && in_ready at edge E0: x[0]<=in_sample, x[i]<=x[i-1] for i=1..TAPS-1 (oldest sample dropped); acc<=0; idx<=0; go to MAC.
  - MAC: combinationally, mul_a=x[idx] and mul_b=h[idx]. At each edge: acc<=acc+mul_c; idx<=idx+1. When idx==TAPS-1, go to OUT at that edge and latch the final sum into out_sample.
  - OUT: out_valid=1, and out_sample is held stable until the handshake. On out_valid && out_ready: go to IDLE and drop out_valid at that edge. in_valid is ignored here; the upstream holds its sample.
- mul_a and mul_b are 0 in IDLE and OUT.
- Latency: out_valid rises at edge E0+TAPS.
- Throughput: with out_ready held at 1, the earliest next accept is at E0+TAPS+2, i.e. one sample per TAPS+2 cycles (10 for TAPS=8).
- Arithmetic:
  - acc is a 64-bit two's-complement register; overflow wraps silently with no saturation.
  - The product is used exactly as the multiplier returns it (already Q32.32); no additional shift.
- out_sample changes only at the edge entering OUT or at reset.

Test Plan:
- Reset: hold rst 3 cycles, then release -> out_valid=0, out_sample=0, mul_a=mul_b=0, in_ready=1 the cycle after release.
- Impulse: write h[i]=(i+1)<<32 (1.0..8.0); feed 0x00000001_00000000 then seven zeros, out_ready=1 -> outputs 0x1_00000000, 0x2_00000000, ..., 0x8_00000000 in order, each out_valid exactly 8 edges after its accept.
- Sign: h[0]=0x00000001_00000000, others 0; input 0xFFFFFFFF_80000000 (-0.5) -> out_sample=0xFFFFFFFF_80000000. Input 0 -> out_sample=0.
- Backpressure: out_ready=0 for 5 cycles while out_valid=1 -> out_sample stable, in_ready=0, in_valid pulses not consumed. Raise out_ready -> one handshake, IDLE next cycle, then accept on the following edge.
- Throughput: continuous in_valid=1, out_ready=1 -> accepts spaced exactly 10 cycles apart for TAPS=8.
- Mid-operation: coef_we in MAC changes no h value. Assert rst at idx=4 -> next cycle IDLE, acc=0, delay line zero, out_valid never asserted for the aborted sample.

Source files
------------

// File: rtl/fir_mac_filter.sv
// fir_mac_filter
//   Time-multiplexed low-pass FIR stage. Every accepted sample is shifted
//   into a TAPS-deep delay line. A serial multiply-accumulate pass then runs
//   over all taps, one tap per clock, using the external combinational
//   Q32.32 multiplier. The finished sum is offered on a valid/ready output.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   coef_we      coefficient write strobe (accepted only while idle)
//   coef_addr    coefficient index
//   coef_data    coefficient value, signed Q32.32
//   in_valid     in_sample is valid
//   in_ready     block can accept a sample
//   in_sample    input sample, signed Q32.32
//   mul_a        multiplier operand A (delay-line tap), 0 when not in a MAC pass
//   mul_b        multiplier operand B (coefficient), 0 when not in a MAC pass
//   mul_c        multiplier product, combinational from mul_a/mul_b
//   out_valid    out_sample is valid
//   out_ready    downstream accepts out_sample
//   out_sample   filtered sample, signed Q32.32
module fir_mac_filter #(
  parameter int TAPS = 8,
  parameter int AW   = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [63:0]   coef_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_sample,
  output logic [63:0]   mul_a,
  output logic [63:0]   mul_b,
  input  logic [63:0]   mul_c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   out_sample
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [63:0]   acc_reg, acc_next;
  logic [63:0]   out_sample_reg, out_sample_next;

  // Delay line and coefficient table. Both need a full clear on reset and a
  // same-cycle read for the multiplier operands, so they live in registers.
  logic [63:0]   x_reg [TAPS];
  logic [63:0]   h_reg [TAPS];

  logic          accept;
  logic          coef_wr;
  logic          mac_active;
  logic [63:0]   mac_sum;
  logic [TAPS-1:0] coef_hit;

  assign in_ready   = (state_reg == ST_IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign out_valid  = (state_reg == ST_OUT) && !rst;
  assign out_sample = out_sample_reg;

  // Operands are only presented during a MAC pass so the multiplier sees
  // zeros while the block is idle or holding a result.
  assign mac_active = (state_reg == ST_MAC) && !rst;
  assign mul_a      = mac_active ? x_reg[idx_reg] : '0;
  assign mul_b      = mac_active ? h_reg[idx_reg] : '0;

  // Product is already Q32.32; accumulate with silent two's-complement wrap.
  assign mac_sum    = acc_reg + mul_c;

  // Coefficients can only change between passes, so a pass always sees a
  // consistent set. A write in the accept cycle lands before tap 0 is read.
  assign coef_wr    = coef_we && (state_reg == ST_IDLE);

  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef_dec
      assign coef_hit[gi] = coef_wr && (coef_addr == AW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        h_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        if (coef_hit[i]) begin
          h_reg[i] <= coef_data;
        end
      end
    end
  end

  // Newest sample enters at x[0]; the oldest falls off the end.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        x_reg[i] <= '0;
      end
    end else if (accept) begin
      x_reg[0] <= in_sample;
      for (int i = 1; i < TAPS; i++) begin
        x_reg[i] <= x_reg[i-1];
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    acc_next        = acc_reg;
    out_sample_next = out_sample_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_MAC;
          idx_next   = '0;
          acc_next   = '0;
        end
      end
      ST_MAC: begin
        acc_next = mac_sum;
        idx_next = idx_reg + AW'(1);
        if (idx_reg == AW'(TAPS - 1)) begin
          // Last tap: the completed sum goes straight to the output register.
          state_next      = ST_OUT;
          out_sample_next = mac_sum;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      acc_reg        <= '0;
      out_sample_reg <= '0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      acc_reg        <= acc_next;
      out_sample_reg <= out_sample_next;
    end
  end

endmodule

// File: tb/tb_fir_mac_filter.sv
// tb_fir_mac_filter
//   Directed bench for fir_mac_filter with TAPS=8. Models the external
//   signed Q32.32 multiplier and checks reset, impulse response, sign
//   handling, backpressure, throughput, coefficient write gating and an
//   abort by reset in the middle of a MAC pass.
module tb_fir_mac_filter;

  localparam int TAPS = 8;
  localparam int AW   = 3;

  logic          clk;
  logic          rst;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [63:0]   coef_data;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   in_sample;
  logic [63:0]   mul_a;
  logic [63:0]   mul_b;
  logic [63:0]   mul_c;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_sample;

  int n_checks;
  int n_errors;

  fir_mac_filter #(.TAPS(TAPS), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sample  (in_sample),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_c      (mul_c),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sample (out_sample)
  );

  // Signed Q32.32 multiplier: full 128-bit product of sign-extended
  // operands, middle 64 bits kept.
  logic [127:0] prod;
  assign prod  = {{64{mul_a[63]}}, mul_a} * {{64{mul_b[63]}}, mul_b};
  assign mul_c = prod[95:32];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [63:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  // Offers one sample, waits (bounded) for acceptance, then waits (bounded)
  // for out_valid. Returns at a falling edge with out_valid observed.
  task automatic send_sample(input logic [63:0] d, output int wait_n,
                             output int lat, output logic [63:0] res);
    in_sample = d;
    in_valid  = 1'b1;
    wait_n    = 0;
    while (!in_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    res = out_sample;
  endtask

  int           w;
  int           lat;
  logic [63:0]  res;
  logic [63:0]  held;
  int           acc_t[$];
  int           cyc;
  int           ov_cnt;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    in_valid  = 1'b0;
    in_sample = '0;
    out_ready = 1'b1;

    // Reset held for three edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_low", 64'(in_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sample", out_sample, 64'd0);
    chk("rst_mul_a", mul_a, 64'd0);
    chk("rst_mul_b", mul_b, 64'd0);
    chk("rst_in_ready_high", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Impulse response: h[i] = i+1, feed 1.0 then zeros.
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), 64'(i + 1) << 32);
    for (int k = 0; k < TAPS; k++) begin
      send_sample((k == 0) ? 64'h0000_0001_0000_0000 : 64'd0, w, lat, res);
      chk($sformatf("imp_out%0d", k), res, 64'(k + 1) << 32);
      chk($sformatf("imp_lat%0d", k), 64'(lat), 64'd8);
    end
    @(negedge clk);

    // Sign: only h[0]=1.0. Delay line now holds 1.0 at x[7] only.
    write_coef(3'd0, 64'h0000_0001_0000_0000);
    for (int i = 1; i < TAPS; i++) write_coef(AW'(i), 64'd0);
    send_sample(64'hFFFF_FFFF_8000_0000, w, lat, res);
    chk("sign_neg_half", res, 64'hFFFF_FFFF_8000_0000);
    send_sample(64'd0, w, lat, res);
    chk("sign_zero", res, 64'd0);
    @(negedge clk);

    // Backpressure: h[1]=2.0 makes an illegally consumed sample visible.
    write_coef(3'd1, 64'h0000_0002_0000_0000);
    out_ready = 1'b0;
    send_sample(64'h0000_0003_0000_0000, w, lat, res);
    chk("bp_out", res, 64'h0000_0003_0000_0000);
    held = out_sample;
    for (int i = 0; i < 5; i++) begin
      in_valid  = i[0];
      in_sample = 64'h0000_0007_0000_0000;
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), out_sample, held);
      chk($sformatf("bp_in_ready%0d", i), 64'(in_ready), 64'd0);
    end
    chk("bp_valid_held", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    send_sample(64'h0000_0005_0000_0000, w, lat, res);
    chk("bp_accept_wait", 64'(w), 64'd1);
    // x[0]=5, x[1]=3 -> 5*1 + 3*2 = 11.
    chk("bp_next_out", res, 64'h0000_000B_0000_0000);
    @(negedge clk);

    // Throughput with in_valid and out_ready held high.
    in_sample = 64'd0;
    in_valid  = 1'b1;
    cyc = 0;
    while (acc_t.size() < 3 && cyc < 100) begin
      if (in_ready) acc_t.push_back(cyc);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("thr_count", 64'(acc_t.size()), 64'd3);
    if (acc_t.size() == 3) begin
      chk("thr_gap0", 64'(acc_t[1] - acc_t[0]), 64'd10);
      chk("thr_gap1", 64'(acc_t[2] - acc_t[1]), 64'd10);
    end
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("thr_drain", 64'(in_ready), 64'd1);

    // Coefficient write during MAC must be ignored (h[1] stays 2.0).
    fork
      send_sample(64'h0000_0001_0000_0000, w, lat, res);
      begin
        @(posedge clk);
        @(negedge clk);
        coef_we   = 1'b1;
        coef_addr = 3'd1;
        coef_data = 64'h0000_0010_0000_0000;
        repeat (3) @(negedge clk);
        coef_we   = 1'b0;
      end
    join
    chk("midwr_out0", res, 64'h0000_0001_0000_0000);
    send_sample(64'd0, w, lat, res);
    chk("midwr_out1", res, 64'h0000_0002_0000_0000);
    @(negedge clk);

    // Reset in the middle of a MAC pass, at idx=4.
    in_sample = 64'h0000_0004_0000_0000;
    in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", 64'(in_ready), 64'd0);
    chk("abort_mul_a", mul_a, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_idle", 64'(in_ready), 64'd1);
    chk("abort_out_sample", out_sample, 64'd0);
    ov_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) ov_cnt++;
    end
    chk("abort_no_valid", 64'(ov_cnt), 64'd0);
    // Coefficients cleared: any input yields zero.
    send_sample(64'h0000_0001_0000_0000, w, lat, res);
    chk("abort_h_clear", res, 64'd0);
    @(negedge clk);
    // Delay line cleared: with h[i]=i+1 only the new 1.0 at x[1] contributes.
    for (int i = 0; i < TAPS; i++) write_coef(AW'(i), 64'(i + 1) << 32);
    send_sample(64'd0, w, lat, res);
    chk("abort_x_clear", res, 64'h0000_0002_0000_0000);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
